// File: rtl/seq_detect_param.sv
// ============================================================================
// Module  : seq_detect_param
// Brief   : Parametrised serial pattern detector with Mealy match, registered
//           match pulse and saturating match counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_detect_param #(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1001,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 x,
  input  logic                 en,
  input  logic                 clear,
  output logic                 z,
  output logic                 z_q,
  output logic [CNT_W-1:0]     match_count,
  output logic [$clog2(N)-1:0] progress
);

  localparam int SW = $clog2(N);
  localparam int NS = 2 ** SW;

  typedef logic [SW-1:0] state_t;

  localparam state_t C_LAST = state_t'(N - 1);

  // Longest pattern prefix (shorter than N) that ends the string
  // "first k pattern bits followed by b"; on a full match this is the
  // KMP failure value, which is exactly the overlapping restart state.
  function automatic int next_state(input int k, input bit b);
    logic [16:0] s;
    int          best;
    bit          ok;
    s    = '0;
    best = 0;
    for (int i = 0; i < k; i++) s[i] = PATTERN[N-1-i];
    s[k] = b;
    for (int j = 1; j < N; j++) begin
      if (j <= k + 1) begin
        ok = 1'b1;
        for (int t = 0; t < j; t++)
          if (s[k+1-j+t] != PATTERN[N-1-t]) ok = 1'b0;
        if (ok) best = j;
      end
    end
    return best;
  endfunction

  if (N < 2 || N > 16) begin : g_bad_n
    $error("seq_detect_param: N must be in 2..16");
  end

  state_t w_nxt0 [NS];
  state_t w_nxt1 [NS];

  for (genvar k = 0; k < NS; k++) begin : g_tbl
    if (k < N) begin : g_live
      localparam state_t C_NX0 = state_t'(next_state(k, 1'b0));
      localparam state_t C_NX1 = state_t'(next_state(k, 1'b1));
      assign w_nxt0[k] = C_NX0;
      assign w_nxt1[k] = C_NX1;
    end else begin : g_pad
      assign w_nxt0[k] = '0;
      assign w_nxt1[k] = '0;
    end
  end

  state_t            r_state;
  state_t            w_next;
  logic              w_z;
  logic              r_zq;
  logic [CNT_W-1:0]  r_count;

  always_comb begin
    w_z    = en & ~clear & (r_state == C_LAST) & (x == PATTERN[0]);
    w_next = r_state;
    if (clear) begin
      w_next = '0;
    end else if (en) begin
      w_next = x ? w_nxt1[r_state] : w_nxt0[r_state];
      if (w_z && !OVERLAP) w_next = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= '0;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_zq    <= 1'b0;
      r_count <= '0;
    end else begin
      r_zq <= w_z;
      if (clear) begin
        r_count <= '0;
      end else if (w_z && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign z           = w_z;
  assign z_q         = r_zq;
  assign match_count = r_count;
  assign progress    = r_state;

endmodule

`default_nettype wire
